mem_port_arbiter: RTL and testbench

// Shares the single 16-bit memory port between the instruction fetch path (two-word opcode+argument

---
 rtl/core_bus_pkg.sv | 16 +
 rtl/mem_beat_reg.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared definitions for the core memory-port arbiter: FSM encoding, default
// bus widths and the byte step between consecutive 16-bit words.
package core_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int WORD_INC   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IF_OPC = 2'b01,
        IF_ARG = 2'b10,
        LS     = 2'b11
    } arb_state_e;

endpackage

// File: rtl/mem_beat_reg.sv
// Bus-side beat register: holds address/write strobe/write data stable and keeps
// mem_req up from grant until the owning FSM ends the access.
module mem_beat_reg
    import core_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              next_i,
    input  logic              stop_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ack_i,
    output logic              ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start_i) begin
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i & ~ADDR_W'(1);
            wdata_d = wdata_i;
        end else if (next_i) begin
            // request stays up: the argument beat follows the opcode beat directly
            addr_d = addr_q + ADDR_W'(WORD_INC);
        end else if (stop_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack_o       = req_q & mem_ack_i;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the two-beat instruction fetch and load/store.
// state  | meaning
// IDLE   | no beat outstanding, arbitrate pending requests
// IF_OPC | opcode beat on the bus
// IF_ARG | argument beat on the bus
// LS     | load/store beat on the bus
module mem_port_arbiter
    import core_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_opc_o,
    output logic [DATA_W-1:0] if_arg_o,
    output logic              if_valid_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_done_o,
    output logic              hold_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    arb_state_e        state_q, state_d;
    logic              last_ls_q, last_ls_d;
    logic              kill_q, kill_d;
    logic              if_valid_q, if_valid_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_opc_q, if_opc_d;
    logic [DATA_W-1:0] if_arg_q, if_arg_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic              beat_start, beat_next, beat_stop, beat_we, beat_ack;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_wdata;
    logic              if_pend, ls_pend, kill_now;

    // a requester whose done pulse is showing is still holding req for this cycle only
    assign if_pend  = if_req_i & ~if_valid_q & ~if_flush_i;
    assign ls_pend  = ls_req_i & ~ls_done_q;
    assign kill_now = kill_q | if_flush_i;

    always_comb begin
        state_d    = state_q;
        last_ls_d  = last_ls_q;
        kill_d     = kill_q;
        if_valid_d = 1'b0;
        ls_done_d  = 1'b0;
        if_opc_d   = if_opc_q;
        if_arg_d   = if_arg_q;
        ls_rdata_d = ls_rdata_q;
        beat_start = 1'b0;
        beat_next  = 1'b0;
        beat_stop  = 1'b0;
        beat_we    = 1'b0;
        beat_addr  = if_addr_i;
        beat_wdata = '0;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (if_pend && (!ls_pend || last_ls_q)) begin
                    beat_start = 1'b1;
                    state_d    = IF_OPC;
                end else if (ls_pend) begin
                    beat_start = 1'b1;
                    beat_we    = ls_we_i;
                    beat_addr  = ls_addr_i;
                    beat_wdata = ls_wdata_i;
                    state_d    = LS;
                end
            end
            IF_OPC: begin
                kill_d = kill_now;
                if (beat_ack) begin
                    if (kill_now) begin
                        beat_stop = 1'b1;
                        kill_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        if_opc_d  = mem_rdata_i;
                        beat_next = 1'b1;
                        state_d   = IF_ARG;
                    end
                end
            end
            IF_ARG: begin
                kill_d = kill_now;
                if (beat_ack) begin
                    beat_stop = 1'b1;
                    kill_d    = 1'b0;
                    state_d   = IDLE;
                    if (!kill_now) begin
                        if_arg_d   = mem_rdata_i;
                        if_valid_d = 1'b1;
                        last_ls_d  = 1'b0;
                    end
                end
            end
            LS: begin
                if (beat_ack) begin
                    beat_stop = 1'b1;
                    ls_done_d = 1'b1;
                    last_ls_d = 1'b1;
                    state_d   = IDLE;
                    if (!mem_we_o) begin
                        ls_rdata_d = mem_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_ls_q  <= 1'b1;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            ls_done_q  <= 1'b0;
            if_opc_q   <= '0;
            if_arg_q   <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_ls_q  <= last_ls_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            ls_done_q  <= ls_done_d;
            if_opc_q   <= if_opc_d;
            if_arg_q   <= if_arg_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    mem_beat_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_beat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (beat_start),
        .next_i      (beat_next),
        .stop_i      (beat_stop),
        .we_i        (beat_we),
        .addr_i      (beat_addr),
        .wdata_i     (beat_wdata),
        .mem_ack_i   (mem_ack_i),
        .ack_o       (beat_ack),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

    assign if_opc_o   = if_opc_q;
    assign if_arg_o   = if_arg_q;
    assign if_valid_o = if_valid_q;
    assign ls_rdata_o = ls_rdata_q;
    assign ls_done_o  = ls_done_q;
    assign hold_o     = (if_req_i & ~if_valid_q) | (ls_req_i & ~ls_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table rows, flush/reset sequences and random rounds
// against a transaction-level model with a shadow memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, ls_req, ls_we;
   logic [15:0] if_addr, ls_addr, ls_wdata;
   logic [15:0] if_opc_o, if_arg_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
   logic        if_valid_o, ls_done_o, hold_o, mem_req_o, mem_we_o;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_opc_o(if_opc_o), .if_arg_o(if_arg_o), .if_valid_o(if_valid_o),
      .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
      .ls_rdata_o(ls_rdata_o), .ls_done_o(ls_done_o), .hold_o(hold_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // external memory: ack after mem_wait idle cycles, one beat at a time
   logic [15:0] mem    [0:32767];
   logic [15:0] shadow [0:32767];
   int          mem_wait = 0;
   int          wcnt = 0;
   int          req_cycles = 0;
   logic [15:0] beat_addr_q[$];
   logic        beat_we_q[$];
   logic [15:0] beat_wd_q[$];
   logic        prev_pend = 1'b0;
   logic [15:0] prev_addr = 16'h0;

   always @(negedge clk) begin
      if (mem_req_o && !rst) begin
         req_cycles++;
         if (prev_pend) chk("addr_stable", mem_addr_o, prev_addr);
         if (wcnt >= mem_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr_o[15:1]];
            if (mem_we_o) mem[mem_addr_o[15:1]] = mem_wdata_o;
            beat_addr_q.push_back(mem_addr_o);
            beat_we_q.push_back(mem_we_o);
            beat_wd_q.push_back(mem_wdata_o);
            wcnt      = 0;
            prev_pend = 1'b0;
         end else begin
            mem_ack   = 1'b0;
            wcnt++;
            prev_pend = 1'b1;
            prev_addr = mem_addr_o;
         end
      end else begin
         mem_ack   = 1'b0;
         wcnt      = 0;
         prev_pend = 1'b0;
      end
   end

   // reference model: service order, completion cycles and data per round
   logic        m_last_ls;
   logic [15:0] m_rdata;
   logic [15:0] exp_addr[$];
   logic        exp_we[$];
   logic [15:0] exp_wd[$];

   task automatic model_round(input logic di, input logic dl, input logic we,
                              input logic [15:0] ia, input logic [15:0] la, input logic [15:0] wd,
                              input int w, output int e_if, output int e_ls,
                              output logic [15:0] e_opc, output logic [15:0] e_arg,
                              output logic [15:0] e_rd);
      logic        fetch_first;
      logic [15:0] a0, a1;
      int          lat_if, lat_ls;
      exp_addr.delete(); exp_we.delete(); exp_wd.delete();
      fetch_first = di && (!dl || m_last_ls);
      lat_if = 1 + 2 * (w + 1);
      lat_ls = 1 + (w + 1);
      e_if = 0; e_ls = 0; e_opc = 16'h0; e_arg = 16'h0;
      a0 = {ia[15:1], 1'b0};
      a1 = a0 + 16'd2;
      for (int pass = 0; pass < 2; pass++) begin
         if (di && (fetch_first == (pass == 0))) begin
            e_if  = (pass == 0) ? lat_if : e_ls + lat_if;
            e_opc = shadow[a0[15:1]];
            e_arg = shadow[a1[15:1]];
            exp_addr.push_back(a0); exp_we.push_back(1'b0); exp_wd.push_back(16'h0);
            exp_addr.push_back(a1); exp_we.push_back(1'b0); exp_wd.push_back(16'h0);
            m_last_ls = 1'b0;
         end else if (dl && (fetch_first != (pass == 0))) begin
            e_ls = (pass == 0) ? lat_ls : e_if + lat_ls;
            if (we) shadow[la[15:1]] = wd;
            else    m_rdata = shadow[la[15:1]];
            exp_addr.push_back({la[15:1], 1'b0}); exp_we.push_back(we); exp_wd.push_back(wd);
            m_last_ls = 1'b1;
         end
      end
      e_rd = m_rdata;
   endtask

   task automatic run_round(input logic di, input logic dl, input logic we,
                            input logic [15:0] ia, input logic [15:0] la, input logic [15:0] wd,
                            input int w, input int e_if, input int e_ls,
                            input logic [15:0] e_opc, input logic [15:0] e_arg,
                            input logic [15:0] e_rd);
      int n_if = 0, n_ls = 0, c_if = 0, c_ls = 0, idle = 0;
      logic [15:0] g_opc = 16'h0, g_arg = 16'h0, g_rd = 16'h0;
      logic h1 = 1'b0;
      mem_wait = w;
      beat_addr_q.delete(); beat_we_q.delete(); beat_wd_q.delete();
      req_cycles = 0;
      if_addr = ia; ls_addr = la; ls_we = we; ls_wdata = wd;
      if_req = di; ls_req = dl;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1) h1 = hold_o;
         if (if_valid_o) begin n_if++; c_if = k; g_opc = if_opc_o; g_arg = if_arg_o; if_req = 1'b0; end
         if (ls_done_o)  begin n_ls++; c_ls = k; g_rd = ls_rdata_o; ls_req = 1'b0; end
         if (!if_req && !ls_req) begin
            idle++;
            if (idle >= 3) break;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      chk("hold_pending", h1, 1'b1);
      chk("hold_after", hold_o, 1'b0);
      chk("if_valid_cnt", n_if, di ? 1 : 0);
      chk("ls_done_cnt", n_ls, dl ? 1 : 0);
      if (di) begin
         chk("if_valid_cycle", c_if, e_if);
         chk("if_opc", g_opc, e_opc);
         chk("if_arg", g_arg, e_arg);
      end
      if (dl) begin
         chk("ls_done_cycle", c_ls, e_ls);
         chk("ls_rdata", g_rd, e_rd);
      end
      chk("beat_cnt", beat_addr_q.size(), exp_addr.size());
      for (int i = 0; i < beat_addr_q.size() && i < exp_addr.size(); i++) begin
         chk("beat_addr", beat_addr_q[i], exp_addr[i]);
         chk("beat_we", beat_we_q[i], exp_we[i]);
         if (exp_we[i]) chk("beat_wdata", beat_wd_q[i], exp_wd[i]);
      end
      chk("req_cycles", req_cycles, (w + 1) * exp_addr.size());
   endtask

   typedef struct {
      logic        di, dl, we;
      logic [15:0] ia, la, wd;
      int          w, e_if, e_ls;
      logic [15:0] e_opc, e_arg, e_rd;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int          x_if, x_ls, n, c;
      logic [15:0] x_opc, x_arg, x_rd, g_opc, g_arg;
      logic        di, dl, we;
      logic [15:0] ia, la, wd;
      int          w;

      tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h2000, 16'h0000, 0, 3, 5, 16'hA900, 16'h1234, 16'h5555};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 3, 0, 16'hA900, 16'h1234, 16'h5555};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h2000, 16'h0000, 0, 5, 2, 16'hCAFE, 16'h0F0F, 16'h5555};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3001, 16'hBEEF, 2, 0, 4, 16'h0000, 16'h0000, 16'h5555};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h3000, 16'h0000, 1, 0, 3, 16'h0000, 16'h0000, 16'hBEEF};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1, 5, 0, 16'hA900, 16'h1234, 16'hBEEF};

      for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 37 + 16'h1357);
      mem[16'h0080] = 16'hA900; mem[16'h0081] = 16'h1234;
      mem[16'h7FFF] = 16'hCAFE; mem[16'h0000] = 16'h0F0F;
      mem[16'h1000] = 16'h5555;
      mem[16'h0200] = 16'h1111; mem[16'h0201] = 16'h2222;
      for (int i = 0; i < 32768; i++) shadow[i] = mem[i];
      m_last_ls = 1'b1;
      m_rdata   = 16'h0;

      rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = 16'h0; ls_addr = 16'h0; ls_wdata = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 16'h0);
      chk("rst_if_valid", if_valid_o, 1'b0);
      chk("rst_ls_done", ls_done_o, 1'b0);
      chk("rst_hold", hold_o, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         model_round(tbl[i].di, tbl[i].dl, tbl[i].we, tbl[i].ia, tbl[i].la, tbl[i].wd, tbl[i].w,
                     x_if, x_ls, x_opc, x_arg, x_rd);
         run_round(tbl[i].di, tbl[i].dl, tbl[i].we, tbl[i].ia, tbl[i].la, tbl[i].wd, tbl[i].w,
                   tbl[i].e_if, tbl[i].e_ls, tbl[i].e_opc, tbl[i].e_arg, tbl[i].e_rd);
      end

      // flush during a slow opcode beat, redirect to 0x0400
      mem_wait = 3;
      beat_addr_q.delete(); beat_we_q.delete(); beat_wd_q.delete();
      n = 0; c = 0; g_opc = 16'h0; g_arg = 16'h0;
      if_addr = 16'h0100; if_req = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 2) begin if_flush = 1'b1; if_addr = 16'h0400; end
         if (k == 3) if_flush = 1'b0;
         if (if_valid_o) begin n++; c = k; g_opc = if_opc_o; g_arg = if_arg_o; if_req = 1'b0; end
      end
      if_req = 1'b0;
      chk("flush_valid_cnt", n, 1);
      chk("flush_valid_cycle", c, 14);
      chk("flush_opc", g_opc, 16'h1111);
      chk("flush_arg", g_arg, 16'h2222);
      chk("flush_beat_cnt", beat_addr_q.size(), 3);
      if (beat_addr_q.size() == 3) begin
         chk("flush_beat0", beat_addr_q[0], 16'h0100);
         chk("flush_beat1", beat_addr_q[1], 16'h0400);
         chk("flush_beat2", beat_addr_q[2], 16'h0402);
      end
      m_last_ls = 1'b0;

      // reset while the argument beat is outstanding
      mem_wait = 2;
      if_addr = 16'h0500; if_req = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_req", mem_req_o, 1'b1);
      chk("pre_rst_addr", mem_addr_o, 16'h0502);
      rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", mem_req_o, 1'b0);
      chk("rst_mid_addr", mem_addr_o, 16'h0);
      chk("rst_mid_we", mem_we_o, 1'b0);
      chk("rst_mid_wdata", mem_wdata_o, 16'h0);
      chk("rst_mid_opc", if_opc_o, 16'h0);
      chk("rst_mid_arg", if_arg_o, 16'h0);
      chk("rst_mid_rdata", ls_rdata_o, 16'h0);
      chk("rst_mid_valid", if_valid_o, 1'b0);
      chk("rst_mid_done", ls_done_o, 1'b0);
      rst = 1'b0;
      m_last_ls = 1'b1;
      m_rdata   = 16'h0;
      model_round(1'b1, 1'b1, 1'b0, 16'h0100, 16'h2000, 16'h0, 0, x_if, x_ls, x_opc, x_arg, x_rd);
      run_round(1'b1, 1'b1, 1'b0, 16'h0100, 16'h2000, 16'h0, 0, 3, 5, 16'hA900, 16'h1234, 16'h5555);

      for (int r = 0; r < 40; r++) begin
         di = 1'($urandom_range(0, 1));
         dl = 1'($urandom_range(0, 1));
         if (!di && !dl) dl = 1'b1;
         we = 1'($urandom_range(0, 1));
         ia = 16'($urandom);
         la = 16'($urandom);
         wd = 16'($urandom);
         w  = int'($urandom_range(0, 3));
         model_round(di, dl, we, ia, la, wd, w, x_if, x_ls, x_opc, x_arg, x_rd);
         run_round(di, dl, we, ia, la, wd, w, x_if, x_ls, x_opc, x_arg, x_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
